debounce_edge_n: RTL and testbench
==================================

# debounce_edge_n

N-channel input conditioning stage that sits directly upstream of the team's D/T/JK flip-flop blocks. It takes raw, asynchronous, possibly bouncing inputs (buttons, switches, external strobes) and produces clean registered levels plus one-cycle rise/fall pulses. Those outputs are safe to drive flop data, toggle or enable inputs. Each channel runs an independent stability-counter state machine. All outputs are registered on one clock.

## Interface
- `N`, 4, number of independent channels.
- `CNT_W`, 16, stability counter width per channel.
- `STABLE`, 1000, consecutive cycles a new value must persist before it is accepted. Legal range is 1..2^CNT_W.
- `clk`  input  1  rising-edge clock for all state.
- `reset`  input  1  asynchronous, active-high reset (the whole block has one clock; reset asynchronous, active-high).
- `din`  input  N  raw asynchronous inputs.
- `level`  output  N  debounced, registered level per channel.
- `rise`  output  N  one-cycle pulse when `level[i]` goes 0→1.
- `fall`  output  N  one-cycle pulse when `level[i]` goes 1→0.
- `changed`  output  1  registered OR of all `rise|fall` bits (same cycle as the pulses).

## Operation
- Input path per channel: `din[i]` feeds a 2-flop synchronizer (`s1`, `s2`). The sample `smp[i]` is `s2[i]`, or `din[i]` directly; see Configuration.
- Per-channel FSM states:
  - STABLE_LO: `level=0`, `cnt=0`.
  - WAIT_HI: `level=0`, counting.
  - STABLE_HI: `level=1`, `cnt=0`.
  - WAIT_LO: `level=1`, counting.
- STABLE_LO→WAIT_HI when `smp=1`, with `cnt<=1`. STABLE_HI→WAIT_LO mirrors this with `smp=0`.
- WAIT_x, sample still differs from level, `cnt<STABLE-1`: `cnt<=cnt+1`.
- WAIT_x, sample still differs from level, `cnt==STABLE-1`: `level` flips, the matching pulse is asserted, `cnt<=0`, and the FSM enters STABLE of the new level.
- WAIT_x, sample equals `level` (bounce): return to the STABLE state, `cnt<=0`, no pulse.
- `STABLE=1`: the FSM never rests in WAIT. `level` follows `smp` one edge later, with a pulse on each change.
- Counter never wraps. It compares against `STABLE-1` at `CNT_W` bits. `STABLE` outside 1..2^CNT_W is an elaboration error via generate-time check.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle, with `changed=1` once.

## Timing
- Reset values: `level=0`, `rise=0`, `fall=0`, `changed=0`, all `cnt=0`, `s1=s2=0`, all FSMs STABLE_LO. These take effect immediately on `reset` assertion, independent of `clk`.
- Latency:
  - `din` change set up before edge E1, input held clean: `level` updates after edge E(STABLE+2) with sync, or E(STABLE) without.
  - `rise`/`fall` are high for exactly the cycle following that edge.
- Pulses never last more than one cycle, and two pulses on one channel are at least `STABLE` cycles apart.
- Reset mid-count: the count is discarded, no pulse is emitted, and `level=0` after release. A `din` held high from before reset release needs the full latency again.
- Reset deassertion is synchronous to `clk` at system level; no internal reset synchronizer.

## Configuration
- `DEBOUNCE_SYNC_EN` defined: 2-flop synchronizer per channel is present; latency `STABLE+2`.
- `DEBOUNCE_SYNC_EN` undefined: `smp=din`. Use this only when `din` is already synchronous to `clk`; latency is `STABLE`, and there are no `s1`/`s2` registers.

## Test plan
- Reset: assert `reset` with `din=4'hF` held, mid-cycle and without a clock edge → all outputs 0 immediately. After release, `level[3:0]` reaches `4'hF` after 6 edges (N=4, STABLE=4, sync on).
- Clean rise, ch0: `din[0]` 0→1 before E1 → `level[0]=1` after E6, `rise[0]=1` for one cycle, `changed=1` in the same cycle, no `fall`.
- Bounce reject: `din[0]` high for 3 cycles, low for 1, then high → `cnt` restarts. `level[0]` rises 6 edges after the final 0→1; no pulse before that.
- Simultaneous: `din` 4'h0→4'h5, then later 4'h5→4'hA → first `rise=4'h5`; then in one cycle `fall=4'h5`, `rise=4'hA`, and `changed` is a single-cycle 1.
- Reset mid-count: `din[1]` high, `reset` pulsed at count 2 → no `rise[1]`. After release, the full 6-edge latency is counted again.
- Sync compiled out, STABLE=1: `din[2]` toggles every 3 cycles → `level[2]` follows one edge later, with alternating `rise`/`fall` pulses per toggle.

Source files
------------

// File: rtl/debounce_edge_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debounce_edge_n : N-channel debouncer with registered level and edge pulses |
// | Optional 2-flop input synchronizer enabled by DEBOUNCE_SYNC_EN.            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module debounce_edge_n #(
  parameter int N      = 4,
  parameter int CNT_W  = 16,
  parameter int STABLE = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_limit  = CNT_W'(STABLE - 1);
  localparam bit               c_single = (STABLE == 1);

  if (STABLE < 1 || longint'(STABLE) > (longint'(1) << CNT_W)) begin : g_bad_stable
    $error("debounce_edge_n: STABLE must lie in 1..2**CNT_W");
  end

  logic [N-1:0] w_smp;

`ifdef DEBOUNCE_SYNC_EN
  logic [N-1:0] s1_q, s1_d;
  logic [N-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign w_smp = s2_q;
`else
  assign w_smp = din;
`endif

  logic [N-1:0] level_q, level_d;
  logic [N-1:0] rise_q, rise_d;
  logic [N-1:0] fall_q, fall_d;
  logic         changed_q, changed_d;

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_c, fall_c;

    // A bounce back to the accepted level is checked before the count limit.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_c  = 1'b0;
      fall_c  = 1'b0;
      case (state_q)
        ST_STABLE_LO: begin
          if (w_smp[i]) begin
            if (c_single) begin
              state_d = ST_STABLE_HI;
              rise_c  = 1'b1;
            end else begin
              state_d = ST_WAIT_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_WAIT_HI: begin
          if (!w_smp[i]) begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == c_limit) begin
            state_d = ST_STABLE_HI;
            cnt_d   = '0;
            rise_c  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE_HI: begin
          if (!w_smp[i]) begin
            if (c_single) begin
              state_d = ST_STABLE_LO;
              fall_c  = 1'b1;
            end else begin
              state_d = ST_WAIT_LO;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_WAIT_LO: begin
          if (w_smp[i]) begin
            state_d = ST_STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == c_limit) begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
            fall_c  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_STABLE_LO;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level_d[i] = (state_d == ST_STABLE_HI) || (state_d == ST_WAIT_LO);
    assign rise_d[i]  = rise_c;
    assign fall_d[i]  = fall_c;
  end

  assign changed_d = |(rise_d | fall_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign level   = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_debounce_edge_n : directed self-checking bench for debounce_edge_n      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_debounce_edge_n;

  localparam int N      = 4;
  localparam int CNT_W  = 16;
  localparam int STABLE = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT  = STABLE + 2;
  localparam int LAT1 = 3;
`else
  localparam int LAT  = STABLE;
  localparam int LAT1 = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] din, level, rise, fall;
  logic         changed;
  logic [N-1:0] din1, level1, rise1, fall1;
  logic         changed1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_edge_n #(.N(N), .CNT_W(CNT_W), .STABLE(STABLE)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  debounce_edge_n #(.N(N), .CNT_W(4), .STABLE(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .din    (din1),
    .level  (level1),
    .rise   (rise1),
    .fall   (fall1),
    .changed(changed1)
  );

  function automatic logic [3*N:0] pack(input logic [N-1:0] l, input logic [N-1:0] r,
                                        input logic [N-1:0] f);
    return {l, r, f, |(r | f)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    din = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_reset();
    logic [N-1:0] el, er;
    reset = 1'b1;
    din   = '0;
    din1  = '0;
    tick();
    tick();
    n_vec++;
    if ({level, rise, fall, changed} !== pack('0, '0, '0)) begin
      n_err++;
      $display("FAIL reset_init: got lvl=%h rise=%h fall=%h chg=%b, want all 0", level, rise, fall, changed);
    end
    n_vec++;
    if ({level1, rise1, fall1, changed1} !== pack('0, '0, '0)) begin
      n_err++;
      $display("FAIL reset_init_b: got lvl=%h rise=%h fall=%h chg=%b, want all 0", level1, rise1, fall1, changed1);
    end
    reset = 1'b0;
    din   = 4'hF;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT) ? 4'hF : 4'h0;
      er = (k == LAT) ? 4'hF : 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack(el, er, '0)) begin
        n_err++;
        $display("FAIL reset_fill e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=0",
                 k, level, rise, fall, changed, el, er);
      end
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({level, rise, fall, changed} !== pack('0, '0, '0)) begin
      n_err++;
      $display("FAIL reset_async: got lvl=%h rise=%h fall=%h chg=%b, want all 0", level, rise, fall, changed);
    end
    tick();
    n_vec++;
    if ({level, rise, fall, changed} !== pack('0, '0, '0)) begin
      n_err++;
      $display("FAIL reset_hold: got lvl=%h rise=%h fall=%h chg=%b, want all 0", level, rise, fall, changed);
    end
    reset = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT) ? 4'hF : 4'h0;
      er = (k == LAT) ? 4'hF : 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack(el, er, '0)) begin
        n_err++;
        $display("FAIL reset_refill e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=0",
                 k, level, rise, fall, changed, el, er);
      end
    end
    drain();
  endtask

  task automatic test_clean_edge();
    logic [N-1:0] el, er, ef;
    din = 4'h1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT) ? 4'h1 : 4'h0;
      er = (k == LAT) ? 4'h1 : 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack(el, er, '0)) begin
        n_err++;
        $display("FAIL clean_rise e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=0",
                 k, level, rise, fall, changed, el, er);
      end
    end
    din = 4'h0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT) ? 4'h0 : 4'h1;
      ef = (k == LAT) ? 4'h1 : 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack(el, '0, ef)) begin
        n_err++;
        $display("FAIL clean_fall e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=0 fall=%h",
                 k, level, rise, fall, changed, el, ef);
      end
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] el, er;
    din = 4'h1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) din = 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack('0, '0, '0)) begin
        n_err++;
        $display("FAIL bounce_hold e%0d: got lvl=%h rise=%h fall=%h chg=%b, want all 0",
                 k, level, rise, fall, changed);
      end
    end
    din = 4'h1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT) ? 4'h1 : 4'h0;
      er = (k == LAT) ? 4'h1 : 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack(el, er, '0)) begin
        n_err++;
        $display("FAIL bounce_rise e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=0",
                 k, level, rise, fall, changed, el, er);
      end
    end
    drain();
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] el, er, ef;
    din = 4'h5;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT) ? 4'h5 : 4'h0;
      er = (k == LAT) ? 4'h5 : 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack(el, er, '0)) begin
        n_err++;
        $display("FAIL simul_rise5 e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=0",
                 k, level, rise, fall, changed, el, er);
      end
    end
    din = 4'hA;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT) ? 4'hA : 4'h5;
      er = (k == LAT) ? 4'hA : 4'h0;
      ef = (k == LAT) ? 4'h5 : 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack(el, er, ef)) begin
        n_err++;
        $display("FAIL simul_swap e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=%h",
                 k, level, rise, fall, changed, el, er, ef);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_count();
    logic [N-1:0] el, er;
    din = 4'h2;
    for (int k = 1; k <= LAT - 2; k++) begin
      tick();
      n_vec++;
      if ({level, rise, fall, changed} !== pack('0, '0, '0)) begin
        n_err++;
        $display("FAIL midrst_count e%0d: got lvl=%h rise=%h fall=%h chg=%b, want all 0",
                 k, level, rise, fall, changed);
      end
    end
    #2 reset = 1'b1;
    tick();
    n_vec++;
    if ({level, rise, fall, changed} !== pack('0, '0, '0)) begin
      n_err++;
      $display("FAIL midrst_in_reset: got lvl=%h rise=%h fall=%h chg=%b, want all 0", level, rise, fall, changed);
    end
    reset = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      el = (k >= LAT) ? 4'h2 : 4'h0;
      er = (k == LAT) ? 4'h2 : 4'h0;
      n_vec++;
      if ({level, rise, fall, changed} !== pack(el, er, '0)) begin
        n_err++;
        $display("FAIL midrst_rise e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=0",
                 k, level, rise, fall, changed, el, er);
      end
    end
    drain();
  endtask

  task automatic test_stable_one();
    logic         hist [0:31];
    logic         elv, prv;
    logic [N-1:0] el, er, ef;
    int           idx;
    prv = 1'b0;
    for (int j = 0; j < 32; j++) hist[j] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      hist[k] = 1'(((k - 1) / 3) % 2);
      din1    = {1'b0, hist[k], 2'b00};
      tick();
      idx = k - LAT1 + 1;
      elv = (idx >= 1) ? hist[idx] : 1'b0;
      el  = {1'b0, elv, 2'b00};
      er  = {1'b0, elv & ~prv, 2'b00};
      ef  = {1'b0, ~elv & prv, 2'b00};
      prv = elv;
      n_vec++;
      if ({level1, rise1, fall1, changed1} !== pack(el, er, ef)) begin
        n_err++;
        $display("FAIL stable1 e%0d: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=%h",
                 k, level1, rise1, fall1, changed1, el, er, ef);
      end
    end
    din1 = '0;
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_stable_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
